// File: rtl/sdram_wr_pre_sched.sv
// SDRAM command issue with per-bank write-recovery (tWR) enforcement on PRE.
// Optional macro WR_PRE_SVA_EN embeds tWR/encoding/stall assertions and a cover.
module sdram_wr_pre_sched #(
  parameter int BA_WIDTH = 3,
  parameter int TWR      = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_op,
  input  logic [BA_WIDTH-1:0] req_bank,
  output logic [1:0]          cmd,
  output logic [BA_WIDTH-1:0] cmd_bank,
  output logic                stall
);

  localparam int         NB      = 1 << BA_WIDTH;
  localparam logic [1:0] CMD_NOP = 2'b00;
  localparam logic [1:0] CMD_PRE = 2'b01;
  localparam logic [1:0] CMD_WR  = 2'b10;
  localparam logic [2:0] TWR_C   = 3'(TWR);

  logic [NB-1:0][2:0]  r_cnt;
  logic                r_pend_valid;
  logic [BA_WIDTH-1:0] r_pend_bank;
  logic [1:0]          r_cmd;
  logic [BA_WIDTH-1:0] r_cmd_bank;
  logic                r_stall;

  logic                w_accept;
  logic                w_pend_free;
  logic                w_req_free;
  logic [1:0]          w_cmd_nxt;
  logic [BA_WIDTH-1:0] w_bank_nxt;
  logic                w_pend_valid_nxt;
  logic [BA_WIDTH-1:0] w_pend_bank_nxt;

  assign req_ready   = !r_pend_valid;
  assign w_accept    = req_valid && req_ready;
  assign w_pend_free = (r_cnt[r_pend_bank] == 3'd0);
  assign w_req_free  = (r_cnt[req_bank] == 3'd0);

  // A held PRE outranks new traffic; it also blocks acceptance via req_ready.
  always_comb begin
    w_cmd_nxt        = CMD_NOP;
    w_bank_nxt       = '0;
    w_pend_valid_nxt = r_pend_valid;
    w_pend_bank_nxt  = r_pend_bank;
    if (r_pend_valid) begin
      if (w_pend_free) begin
        w_cmd_nxt        = CMD_PRE;
        w_bank_nxt       = r_pend_bank;
        w_pend_valid_nxt = 1'b0;
      end
    end else if (w_accept) begin
      if (!req_op) begin
        w_cmd_nxt  = CMD_WR;
        w_bank_nxt = req_bank;
      end else if (w_req_free) begin
        w_cmd_nxt  = CMD_PRE;
        w_bank_nxt = req_bank;
      end else begin
        w_pend_valid_nxt = 1'b1;
        w_pend_bank_nxt  = req_bank;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_pend_valid <= 1'b0;
      r_pend_bank  <= '0;
      r_cmd        <= CMD_NOP;
      r_cmd_bank   <= '0;
      r_stall      <= 1'b0;
    end else begin
      // A WR reloads its bank's counter even mid-recovery, extending tWR.
      for (int b = 0; b < NB; b++) begin
        if (w_cmd_nxt == CMD_WR && w_bank_nxt == BA_WIDTH'(b))
          r_cnt[b] <= TWR_C;
        else if (r_cnt[b] != 3'd0)
          r_cnt[b] <= r_cnt[b] - 3'd1;
      end
      r_pend_valid <= w_pend_valid_nxt;
      r_pend_bank  <= w_pend_bank_nxt;
      r_cmd        <= w_cmd_nxt;
      r_cmd_bank   <= w_bank_nxt;
      r_stall      <= w_pend_valid_nxt;
    end
  end

  assign cmd      = r_cmd;
  assign cmd_bank = r_cmd_bank;
  assign stall    = r_stall;

`ifdef WR_PRE_SVA_EN
  genvar gb;
  generate
    for (gb = 0; gb < NB; gb++) begin : g_sva
      logic w_wr_b, w_pre_b;
      assign w_wr_b  = (r_cmd == CMD_WR)  && (r_cmd_bank == BA_WIDTH'(gb));
      assign w_pre_b = (r_cmd == CMD_PRE) && (r_cmd_bank == BA_WIDTH'(gb));
      a_twr: assert property (@(posedge clk) disable iff (rst)
        w_wr_b |-> ##1 (!w_pre_b) [*TWR]);
      c_twr_exact: cover property (@(posedge clk) disable iff (rst)
        w_wr_b ##(TWR+1) w_pre_b);
    end
  endgenerate

  a_cmd_enc: assert property (@(posedge clk) disable iff (rst) r_cmd != 2'b11);
  a_stall:   assert property (@(posedge clk) disable iff (rst) r_pend_valid |-> r_stall);
`endif

endmodule

// File: tb/tb_sdram_wr_pre_sched.sv
// Directed tWR scheduling checks plus a random phase with an independent tWR gap monitor.
module tb_sdram_wr_pre_sched;
  localparam int BA_WIDTH = 3;
  localparam int TWR      = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                req_valid;
  logic                req_ready;
  logic                req_op;
  logic [BA_WIDTH-1:0] req_bank;
  logic [1:0]          cmd;
  logic [BA_WIDTH-1:0] cmd_bank;
  logic                stall;

  int n_cmp = 0;
  int n_err = 0;

  sdram_wr_pre_sched #(.BA_WIDTH(BA_WIDTH), .TWR(TWR)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_bank(req_bank), .cmd(cmd), .cmd_bank(cmd_bank),
    .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic op, input int bank);
    req_valid = v;
    req_op    = op;
    req_bank  = BA_WIDTH'(bank);
  endtask

  // Leaves the bench at cycle 0 with reset state checked.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    drive(0, 0, 0);
    tick;
    rst = 1'b0;
    chk({tag, "_rst_cmd"},   cmd, 2'b00);
    chk({tag, "_rst_bank"},  cmd_bank, 0);
    chk({tag, "_rst_stall"}, stall, 0);
    chk({tag, "_rst_ready"}, req_ready, 1);
  endtask

  task automatic expect_out(input string tag, input logic [1:0] c, input int b,
                            input logic s, input logic r);
    chk({tag, "_cmd"},   cmd, c);
    chk({tag, "_bank"},  cmd_bank, b);
    chk({tag, "_stall"}, stall, s);
    chk({tag, "_ready"}, req_ready, r);
  endtask

  int last_wr [8];
  int cyc;

  initial begin
    rst = 1'b1;
    drive(0, 0, 0);
    tick;

    // A: WR b2, then PRE b2 held for tWR, then a WR accepted while PRE is on cmd
    do_reset("A");
    drive(1, 0, 2); tick;                       // cycle 1
    expect_out("A_c1", 2'b10, 2, 0, 1);
    drive(1, 1, 2); tick;                       // cycle 2
    drive(0, 0, 0);
    expect_out("A_c2", 2'b00, 0, 1, 0);
    for (int k = 3; k <= 5; k++) begin
      tick;
      expect_out($sformatf("A_c%0d", k), 2'b00, 0, 1, 0);
    end
    tick;                                       // cycle 6
    expect_out("A_c6", 2'b01, 2, 0, 1);
    drive(1, 0, 4); tick;                       // cycle 7
    drive(0, 0, 0);
    expect_out("A_c7", 2'b10, 4, 0, 1);

    // B: PRE to a different bank is unaffected by the WR
    do_reset("B");
    drive(1, 0, 2); tick;
    drive(1, 1, 5); tick;                       // cycle 2
    drive(0, 0, 0);
    expect_out("B_c2", 2'b01, 5, 0, 1);
    tick;
    expect_out("B_c3", 2'b00, 0, 0, 1);

    // C: second WR extends recovery; PRE lands TWR+1 after the latest WR
    do_reset("C");
    drive(1, 0, 3); tick;                       // cycle 1
    drive(0, 0, 0);
    expect_out("C_c1", 2'b10, 3, 0, 1);
    drive(1, 0, 3); tick;                       // cycle 2 (request ignored? no: valid)
    drive(0, 0, 0);
    expect_out("C_c2", 2'b10, 3, 0, 1);
    tick;                                       // cycle 3 idle
    expect_out("C_c3", 2'b00, 0, 0, 1);
    drive(1, 1, 3); tick;                       // cycle 4
    drive(0, 0, 0);
    expect_out("C_c4", 2'b00, 0, 1, 0);
    tick; tick;                                 // cycle 6
    expect_out("C_c6", 2'b00, 0, 1, 0);
    tick;                                       // cycle 7: last WR at 2, PRE at 7
    expect_out("C_c7", 2'b01, 3, 0, 1);

    // C2: spec vector -- WRs on cmd at 1 and 3, PRE requested at 3, PRE at 8
    do_reset("C2");
    drive(1, 0, 3); tick;                       // cycle 1
    drive(0, 0, 0); tick;                       // cycle 2
    drive(1, 0, 3); tick;                       // cycle 3
    expect_out("C2_c3", 2'b10, 3, 0, 1);
    drive(1, 1, 3); tick;                       // cycle 4
    drive(0, 0, 0);
    expect_out("C2_c4", 2'b00, 0, 1, 0);
    tick; tick; tick;                           // cycle 7
    expect_out("C2_c7", 2'b00, 0, 1, 0);
    tick;                                       // cycle 8
    expect_out("C2_c8", 2'b01, 3, 0, 1);

    // D: reset while a PRE is pending discards it
    do_reset("D");
    drive(1, 0, 1); tick;
    drive(1, 1, 1); tick;                       // cycle 2, pend held
    drive(0, 0, 0);
    expect_out("D_c2", 2'b00, 0, 1, 0);
    rst = 1'b1; tick; rst = 1'b0;
    expect_out("D_rst", 2'b00, 0, 0, 1);
    for (int k = 0; k < 8; k++) begin
      tick;
      chk("D_no_pre", cmd, 2'b00);
    end

    // E: random traffic, every PRE must be more than TWR cycles after its bank's last WR
    do_reset("E");
    for (int b = 0; b < 8; b++) last_wr[b] = -100;
    cyc = 0;
    for (int k = 0; k < 3000; k++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7));
      tick;
      cyc++;
      if (cmd == 2'b11) chk("E_enc", cmd, 2'b00);
      if (cmd == 2'b10) last_wr[cmd_bank] = cyc;
      if (cmd == 2'b01) chk("E_twr_gap", (cyc - last_wr[cmd_bank]) > TWR, 1);
      if (cmd == 2'b00) chk("E_nop_bank", cmd_bank, 0);
      chk("E_stall_ready", stall, !req_ready);
    end
    drive(0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
